// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle for piso_tx: word load on one side, serial bit stream on the other.
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             sout_last;

  modport master (
    output in, load_valid,
    input  load_ready, sout, sout_valid, sout_first, sout_last
  );

  modport slave (
    input  in, load_valid,
    output load_ready, sout, sout_valid, sout_first, sout_last
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with framing flags; back-to-back frames reload on the last bit.
// Optional even-parity trailer bit enabled by defining PIS_TX_PARITY_EN.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic       clock,
  input logic       reset,
  piso_tx_if.slave  bus
);

`ifdef PIS_TX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             last_bit;
  logic             load_ready;
  logic             tx_bit;
`ifdef PIS_TX_PARITY_EN
  logic             par_q;
`endif

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(FRAME - 1));
  assign accept   = bus.load_valid && load_ready;

`ifdef PIS_TX_PARITY_EN
  // Data bits are exhausted at count WIDTH; the held parity bit goes out instead.
  assign tx_bit = (cnt_q == CNT_W'(WIDTH)) ? par_q : head_bit(sr_q);
`else
  assign tx_bit = head_bit(sr_q);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // Reset forces the state asynchronously; ready must also drop while it is held.
        load_ready = !reset;
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
          load_ready = 1'b1;
          state_d    = bus.load_valid ? SHIFT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
`ifdef PIS_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (accept) begin
      sr_q  <= bus.in;
      cnt_q <= '0;
`ifdef PIS_TX_PARITY_EN
      par_q <= ^bus.in;
`endif
    end else if ((state_q == SHIFT) && !last_bit) begin
      sr_q  <= shift_out(sr_q);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.sout       = (state_q == SHIFT) && tx_bit;
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.sout_first = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.sout_last  = last_bit;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in, input, WIDTH bits: parallel word to serialize.
REQ-006 The block SHALL have port load_valid, input, 1 bit: in holds a word to send.
REQ-007 The block SHALL have port load_ready, output, 1 bit: block accepts a word this cycle.
REQ-008 The block SHALL have port sout, output, 1 bit: serial data bit.
REQ-009 The block SHALL have port sout_valid, output, 1 bit: sout carries a frame bit this cycle.
REQ-010 The block SHALL have port sout_first, output, 1 bit: current bit is the first bit of a frame.
REQ-011 The block SHALL have port sout_last, output, 1 bit: current bit is the last bit of a frame.

Function
REQ-012 Two states SHALL exist: IDLE and SHIFT; FRAME = WIDTH, or WIDTH+1 under PARITY_EN.
REQ-013 Accept: a word SHALL be captured on a rising edge where load_valid=1 and load_ready=1; capture sets the shift register to in, bit counter to 0, and state to SHIFT.
REQ-014 load_ready SHALL be 1 in IDLE, 1 in SHIFT while the counter is FRAME-1, and 0 otherwise.
REQ-015 Latency: the first frame bit SHALL appear on sout with sout_valid=1 in the cycle immediately following the accepting edge.
REQ-016 In SHIFT, each rising edge SHALL advance one bit: counter +1, shift register shifted toward the transmit end, zero-filled.
REQ-017 sout SHALL be driven combinationally from register state: shift register bit WIDTH-1 if MSB_FIRST=1, bit 0 otherwise; sout_valid=1 exactly in SHIFT.
REQ-018 sout_first SHALL be 1 when in SHIFT and the counter is 0; sout_last SHALL be 1 when in SHIFT and the counter is FRAME-1.
REQ-019 Frame end: on the edge that ends the last bit, the block SHALL reload and stay in SHIFT if load_valid=1; otherwise it SHALL go to IDLE.
REQ-020 Back-to-back frames SHALL have no idle gap between bits.
REQ-021 load_valid while load_ready=0 SHALL be ignored: no capture, no corruption of the frame in flight.
REQ-022 In IDLE, sout, sout_valid, sout_first and sout_last SHALL be 0.
REQ-023 in SHALL be sampled only on the accepting edge; later changes to in SHALL not affect the frame.

Reset
REQ-024 reset=1 SHALL immediately, without waiting for a clock edge, force state IDLE, shift register 0, counter 0 and parity register 0.
REQ-025 While reset=1, outputs SHALL be: load_ready=0, sout=0, sout_valid=0, sout_first=0, sout_last=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further bits emitted.
REQ-027 After reset deasserts, load_ready SHALL be 1 and the first clock edge with load_valid=1 SHALL be accepted.

Configuration
REQ-028 Macro PIS_TX_PARITY_EN, when defined, SHALL append one even-parity bit after the WIDTH data bits.
REQ-029 The parity bit SHALL be the XOR of all bits of the captured word, so total ones per frame is even; it is computed at the accepting edge and held in a register; it is the sout_last bit.
REQ-030 Without PIS_TX_PARITY_EN, FRAME=WIDTH and no parity logic SHALL be present.

Verification
REQ-031 Case MSB_FIRST=1, no parity: load 0xA5 at edge N -> cycles N+1..N+8 sout=1,0,1,0,0,1,0,1; sout_first at N+1, sout_last at N+8; IDLE at N+9.
REQ-032 Case MSB_FIRST=0: load 0x01 -> sout=1 in the first bit cycle, then 0 for 7 cycles.
REQ-033 Back-to-back: 0xA5, then 0x3C presented during the last bit of 0xA5 -> 16 contiguous valid bits 10100101 00111100, sout_valid never drops.
REQ-034 Busy: load 0xFF, pulse load_valid with 0x00 at bit 3 -> ignored, all 8 bits 1, load_ready=0 at bit 3.
REQ-035 Reset mid-frame: assert reset between edges during bit 4 of 0xA5 -> sout_valid=0 at once, no clock needed; after release load_ready=1 and next load 0x3C sends correctly.
REQ-036 Parity: with PIS_TX_PARITY_EN, load 0x07 -> 9 bits 0,0,0,0,0,1,1,1,1; sout_last on the 9th bit. Load 0x03 -> parity bit 0.
